// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the core's data-memory path.
//   XLEN          - data/address width
//   operation_e   - memory-stage operation encoding (OP_NONE = no access)
//   dmem_state_e  - dmem_master sequencing states
//   BE_*          - byte-enable patterns used when building bus requests
//   is_load / is_store / is_load_store / is_misaligned - op classification helpers
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } operation_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_e;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load(operation_e op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(operation_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_load_store(operation_e op);
    return is_load(op) || is_store(op);
  endfunction

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic is_misaligned(operation_e op, logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      OP_LW, OP_SW:         mis = (off != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword out of a returned memory word
// and sign- or zero-extends it to XLEN.
//   op_i     - load operation (non-loads produce 0)
//   off_i    - byte offset addr[1:0] of the access
//   rdata_i  - raw word from memory
//   result_o - aligned, extended load result
module load_align
  import riscv_pkg::*;
(
  input  operation_e       op_i,
  input  logic [1:0]       off_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [XLEN-1:0]  result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[7:0];
    case (off_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
      default: byte_lane = rdata_i[7:0];
    endcase
    // Only addr[1] chooses the halfword; addr[0] is ignored here.
    half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    result_o = '0;
    case (op_i)
      OP_LB:  result_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      OP_LBU: result_o = {{(XLEN-8){1'b0}}, byte_lane};
      OP_LH:  result_o = {{(XLEN-16){half_lane[15]}}, half_lane};
      OP_LHU: result_o = {{(XLEN-16){1'b0}}, half_lane};
      OP_LW:  result_o = rdata_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_master.sv
// dmem_master: load/store initiator between the memory pipeline stage and the
// data-memory responder. One access outstanding at a time; the pipeline is
// stalled from acceptance until the single-cycle completion pulse.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned LH/LHU/SH/LW/SW complete one cycle after acceptance
//               with misalign_o=1 and no bus access
//   undefined - misalign_o is tied 0 and offending low address bits are ignored
//
// Ports:
//   clk_i, rst_i          - clock (rising edge), asynchronous active-high reset
//   req_valid_i/op/addr/wdata/rd_addr_i - memory-stage operation
//   stall_o               - hold upstream pipeline (combinational)
//   rsp_valid_o           - one-cycle completion pulse
//   rsp_rdata_o           - aligned/extended load result, 0 for stores/faults
//   rsp_rd_addr_o         - destination register of the completed access
//   misalign_o            - completion was a misaligned-access fault
//   mem_req_o/we/addr/be/wdata_o - request to data memory (held until grant)
//   mem_gnt_i             - request accepted by responder
//   mem_rvalid_i/rdata_i  - read data / write acknowledge
module dmem_master
  import riscv_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  operation_e       req_op_i,
  input  logic [XLEN-1:0]  req_addr_i,
  input  logic [XLEN-1:0]  req_wdata_i,
  input  logic [4:0]       req_rd_addr_i,
  output logic             stall_o,
  output logic             rsp_valid_o,
  output logic [XLEN-1:0]  rsp_rdata_o,
  output logic [4:0]       rsp_rd_addr_o,
  output logic             misalign_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i
);

  dmem_state_e     state_q, state_d;
  operation_e      op_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] rdata_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;

  logic            accept;
  logic            fault;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] load_result;

  assign accept = req_valid_i && is_load_store(req_op_i);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;

  assign fault = is_misaligned(req_op_i, req_addr_i[1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (state_q == IDLE && accept) begin
      misalign_q <= fault;
    end
  end

  // Qualified so the flag never lingers outside the completion pulse.
  assign misalign_o = misalign_q && (state_q == RESP);
`else
  assign fault      = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fault ? RESP : REQ;
      REQ:  if (mem_gnt_i) state_d = WAIT;
      WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------- FSM outputs
  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: stall_o = accept;
      REQ: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
      end
      WAIT: stall_o = 1'b1;
      // Stall drops here so the pipeline advances on the completing edge.
      RESP: rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Byte enables and lane-replicated store data. Only addr[1] steers a
  // halfword and words ignore both low bits, so unaligned accesses fold onto
  // the containing lane when fault detection is off.
  always_comb begin
    be_d    = BE_WORD;
    wdata_d = '0;
    case (req_op_i)
      OP_SB: begin
        be_d    = BE_BYTE0 << req_addr_i[1:0];
        wdata_d = {4{req_wdata_i[7:0]}};
      end
      OP_SH: begin
        be_d    = req_addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_d = {2{req_wdata_i[15:0]}};
      end
      OP_SW: wdata_d = req_wdata_i;
      default: ;
    endcase
  end

  load_align u_load_align (
    .op_i     (op_q),
    .off_i    (off_q),
    .rdata_i  (mem_rdata_i),
    .result_o (load_result)
  );

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q        <= OP_NONE;
      off_q       <= 2'b00;
      rd_addr_q   <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else if (state_q == IDLE && accept) begin
      op_q        <= req_op_i;
      off_q       <= req_addr_i[1:0];
      rd_addr_q   <= req_rd_addr_i;
      rdata_q     <= '0;   // stores and faults complete with zero data
      mem_we_q    <= is_store(req_op_i);
      mem_addr_q  <= {req_addr_i[XLEN-1:2], 2'b00};
      mem_be_q    <= be_d;
      mem_wdata_q <= wdata_d;
    end else if (state_q == WAIT && mem_rvalid_i) begin
      rdata_q     <= is_load(op_q) ? load_result : '0;
    end
  end

  assign rsp_rdata_o   = rdata_q;
  assign rsp_rd_addr_o = rd_addr_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_be_o      = mem_be_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule
